// File: rtl/memory_array_pkg.sv
// Shared types and helpers for the multi-read-port storage array.
package memory_array_pkg;

   localparam int unsigned MAX_READ_PORTS = 4;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } clr_state_t;

   function automatic int unsigned clog2(input int unsigned value);
      int unsigned result;
      int unsigned v;
      result = 0;
      v      = (value > 0) ? value - 1 : 0;
      while (v > 0) begin
         result = result + 1;
         v      = v >> 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/memory_array_clear_seq.sv
// Clear sequencer: zeroes every entry after reset and on FLUSH, holding READY low meanwhile.
// Instantiated only when MEMORY_ARRAY_CLEAR_EN is defined.
module memory_array_clear_seq
   import memory_array_pkg::*;
#(
   parameter int unsigned DEPTH      = 512,
   parameter int unsigned ADDR_WIDTH = 9
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  FLUSH,
   output logic                  clr_en,
   output logic [ADDR_WIDTH-1:0] clr_addr,
   output logic                  READY
);

   localparam int unsigned CNT_W = (clog2(DEPTH) > 0) ? clog2(DEPTH) : 1;

   clr_state_t       state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             last;

   assign last = (cnt_q == CNT_W'(DEPTH - 1));

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= CLEAR;
         cnt_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (FLUSH) begin
                  state_q <= CLEAR;
                  cnt_q   <= '0;
               end
            end
            CLEAR: begin
               // FLUSH is deliberately not looked at here: an ongoing clear is never restarted.
               if (last) begin
                  state_q <= IDLE;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            default: begin
               state_q <= IDLE;
               cnt_q   <= '0;
            end
         endcase
      end
   end

   assign clr_en   = (state_q == CLEAR);
   assign clr_addr = ADDR_WIDTH'(cnt_q);
   assign READY    = (state_q == IDLE);

endmodule

// File: rtl/memory_array.sv
// Multi-read-port storage array with bit-masked writes and write-first bypass.
// Optional clear sequencer enabled by defining MEMORY_ARRAY_CLEAR_EN.
module memory_array
   import memory_array_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 9,
   parameter int unsigned DEPTH      = 512,
   parameter int unsigned READ_PORTS = 2
) (
   input  logic                             CLK,
   input  logic                             RST,
   output logic                             READY,
   input  logic                             FLUSH,
   input  logic                             WR_EN,
   input  logic [ADDR_WIDTH-1:0]            WR_ADDR,
   input  logic [DATA_WIDTH-1:0]            WR_DATA,
   input  logic [DATA_WIDTH-1:0]            WR_MASK,
   input  logic [READ_PORTS-1:0]            RD_EN,
   input  logic [READ_PORTS*ADDR_WIDTH-1:0] RD_ADDR,
   output logic [READ_PORTS*DATA_WIDTH-1:0] RD_DATA,
   output logic [READ_PORTS-1:0]            RD_VALID
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic                  ready;
   logic                  clr_en;
   logic [ADDR_WIDTH-1:0] clr_addr;

`ifdef MEMORY_ARRAY_CLEAR_EN
   memory_array_clear_seq #(
      .DEPTH      (DEPTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_clear_seq (
      .CLK      (CLK),
      .RST      (RST),
      .FLUSH    (FLUSH),
      .clr_en   (clr_en),
      .clr_addr (clr_addr),
      .READY    (ready)
   );
`else
   logic ready_q;
   logic unused_flush;

   always_ff @(posedge CLK) begin
      if (RST) begin
         ready_q <= 1'b0;
      end else begin
         ready_q <= 1'b1;
      end
   end

   assign ready        = ready_q;
   assign clr_en       = 1'b0;
   assign clr_addr     = '0;
   assign unused_flush = FLUSH;
`endif

   assign READY = ready;

   logic                  wr_in_range;
   logic                  wr_fire;
   logic [DATA_WIDTH-1:0] wr_old;
   logic [DATA_WIDTH-1:0] wr_merged;

   assign wr_in_range = (32'(WR_ADDR) < DEPTH);
   assign wr_fire     = WR_EN && ready && wr_in_range;

   always_comb begin
      wr_old = '0;
      if (wr_in_range) begin
         wr_old = mem[WR_ADDR];
      end
   end

   assign wr_merged = (wr_old & ~WR_MASK) | (WR_DATA & WR_MASK);

   // Clear and user writes never coincide: the clear only runs while ready is low.
   always_ff @(posedge CLK) begin
      if (clr_en) begin
         mem[clr_addr] <= '0;
      end else if (wr_fire) begin
         mem[WR_ADDR] <= wr_merged;
      end
   end

   for (genvar p = 0; p < READ_PORTS; p++) begin : g_port
      logic [ADDR_WIDTH-1:0] rd_addr;
      logic                  rd_in_range;
      logic                  rd_hit;
      logic                  rd_fire;
      logic [DATA_WIDTH-1:0] rd_word;
      logic [DATA_WIDTH-1:0] rd_data_q;
      logic                  rd_valid_q;

      assign rd_addr     = RD_ADDR[p*ADDR_WIDTH +: ADDR_WIDTH];
      assign rd_in_range = (32'(rd_addr) < DEPTH);
      assign rd_hit      = wr_fire && (rd_addr == WR_ADDR);
      assign rd_fire     = RD_EN[p] && ready;

      always_comb begin
         rd_word = '0;
         if (rd_in_range) begin
            rd_word = rd_hit ? wr_merged : mem[rd_addr];
         end
      end

      always_ff @(posedge CLK) begin
         if (RST) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
         end else begin
            rd_valid_q <= rd_fire;
            if (rd_fire) begin
               rd_data_q <= rd_word;
            end
         end
      end

      assign RD_DATA[p*DATA_WIDTH +: DATA_WIDTH] = rd_data_q;
      assign RD_VALID[p]                         = rd_valid_q;
   end

endmodule
